// File: rtl/regfile_reader.sv
// regfile_reader: walks a register-file address range and streams {addr,data} over valid/ready
module regfile_reader #(
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_start,
  input  logic [AW-1:0] i_start_addr,
  input  logic [AW:0]   i_count,
  output logic [AW-1:0] o_ra,
  input  logic [DW-1:0] i_rd,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic [AW-1:0] o_out_addr,
  output logic [DW-1:0] o_out_data,
  output logic          o_busy,
  output logic          o_done
);
  typedef enum logic [1:0] {IDLE, READ, SEND, FIN} state_t;
  localparam logic [AW:0]   ONE  = 1;
  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);
  state_t        r_state, w_next;
  logic [AW-1:0] r_idx, r_addr;
  logic [AW:0]   r_rem;
  logic [DW-1:0] r_data;
  logic          r_valid;
  logic          w_acc;
  assign w_acc       = r_valid & i_out_ready;
  assign o_ra        = r_idx;
  assign o_out_valid = r_valid;
  assign o_out_addr  = r_addr;
  assign o_out_data  = r_data;
  assign o_busy      = r_state != IDLE;
  assign o_done      = r_state == FIN;
  // state register
  always_ff @(posedge clk)
    r_state <= reset ? IDLE : w_next;
  // next-state: a zero-length request goes straight to FIN so done still pulses
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: w_next = i_start ? (i_count == '0 ? FIN : READ) : IDLE;
      READ: w_next = SEND;
      SEND: w_next = w_acc ? (r_rem == ONE ? FIN : READ) : SEND;
      FIN:  w_next = IDLE;
    endcase
  end
  // datapath: latch walk, capture word in READ, advance on acceptance
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx   <= '0;
      r_rem   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      if (r_state == IDLE && i_start && i_count != '0) begin
        r_idx <= i_start_addr;
        r_rem <= i_count;
      end
      if (r_state == READ) begin
        r_data  <= i_rd;
        r_addr  <= r_idx;
        r_valid <= 1'b1;
      end
      if (r_state == SEND && w_acc) begin
        r_rem   <= r_rem - ONE;
        r_valid <= 1'b0;
        if (r_rem != ONE) r_idx <= r_idx == LAST ? '0 : r_idx + 1'b1;
      end
    end
  end
endmodule
